// File: rtl/thresh_editor_pkg.sv
// Shared types and BCD digit helpers for the alarm-threshold editor.
// Optional feature macro used by the top: THRESH_TIMEOUT_EN (edit auto-abort).
package thresh_pkg;

    // Editor mode: IDLE shows the committed value, EDIT owns the working copy.
    typedef enum logic {
        IDLE = 1'b0,
        EDIT = 1'b1
    } state_t;

    // One BCD digit.
    typedef logic [3:0] bcd_t;

    // Increment with 9 -> 0 wrap; a malformed digit (>9) is treated as 9.
    function automatic bcd_t bcd_inc(input bcd_t d);
        bcd_t v;
        v = (d > 4'd9) ? 4'd9 : d;
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    // Decrement with 0 -> 9 wrap; a malformed digit (>9) is treated as 9.
    function automatic bcd_t bcd_dec(input bcd_t d);
        bcd_t v;
        v = (d > 4'd9) ? 4'd9 : d;
        return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

endpackage

// File: rtl/thresh_editor_if.sv
// Front-panel key levels in, committed/display values out.
// Keys are plain debounced levels: there is no valid/ready handshake on this
// bus; every output is a registered level except commit_pulse, a 1-cycle strobe.
interface thresh_editor_if #(
    parameter int DIGITS = 3
) ();
    import thresh_pkg::*;

    localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  key_mode;
    logic                  key_sel;
    logic                  key_inc;
    logic                  key_dec;
    logic [4*DIGITS-1:0]   thresh_bcd;
    logic [4*DIGITS-1:0]   edit_bcd;
    logic                  edit_active;
    logic [SEL_W-1:0]      digit_sel;
    logic                  blink;
    logic                  commit_pulse;
    state_t                state_dbg;

    // Key source / display side.
    modport master (
        output key_mode, key_sel, key_inc, key_dec,
        input  thresh_bcd, edit_bcd, edit_active, digit_sel, blink,
               commit_pulse, state_dbg
    );

    // Editor side.
    modport slave (
        input  key_mode, key_sel, key_inc, key_dec,
        output thresh_bcd, edit_bcd, edit_active, digit_sel, blink,
               commit_pulse, state_dbg
    );

endinterface

// File: rtl/thresh_editor_key_edge.sv
// Key front end: 2-FF synchroniser followed by a registered rising-edge pulse.
// The detector only arms after it has seen the synchronised key low, so a key
// held high through reset release never produces an edge.
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_rise
);

    logic       sync1_q;
    logic       sync2_q;
    logic       sync2_d_q;
    logic [1:0] primed_q;
    logic       seen_low_q;
    logic       rise_q;

    // Synchronise the raw key, remember its last value and emit a 1-cycle rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync2_d_q  <= 1'b0;
            primed_q   <= 2'b00;
            seen_low_q <= 1'b0;
            rise_q     <= 1'b0;
        end else begin
            sync1_q    <= key_in;
            sync2_q    <= sync1_q;
            sync2_d_q  <= sync2_q;
            // primed_q[1] marks that sync2_q now carries a real sample, not reset value
            primed_q   <= {primed_q[0], 1'b1};
            seen_low_q <= seen_low_q | (primed_q[1] & ~sync2_q);
            rise_q     <= sync2_q & ~sync2_d_q & seen_low_q;
        end
    end

    assign key_rise = rise_q;

endmodule

// File: rtl/thresh_editor.sv
// Alarm-threshold editor: holds a committed BCD threshold and edits a working
// copy digit by digit from four front-panel keys.
// Optional: define THRESH_TIMEOUT_EN to abort an idle edit after TIMEOUT_CYC cycles.
module thresh_editor
    import thresh_pkg::*;
#(
    parameter int                  DIGITS      = 3,
    parameter logic [4*DIGITS-1:0] RESET_BCD   = 'h200,
    parameter int                  BLINK_DIV   = 12_500_000,
    parameter int                  TIMEOUT_CYC = 250_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    thresh_editor_if.slave bus
);

    localparam int W       = 4 * DIGITS;
    localparam int SEL_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BLINK_W = $clog2(BLINK_DIV);

    // Key edges, one cycle wide, three cycles after the raw key rises.
    logic mode_e, sel_e, inc_e, dec_e;

    key_edge u_mode (.clk(clk), .rst_n(rst_n), .key_in(bus.key_mode), .key_rise(mode_e));
    key_edge u_sel  (.clk(clk), .rst_n(rst_n), .key_in(bus.key_sel),  .key_rise(sel_e));
    key_edge u_inc  (.clk(clk), .rst_n(rst_n), .key_in(bus.key_inc),  .key_rise(inc_e));
    key_edge u_dec  (.clk(clk), .rst_n(rst_n), .key_in(bus.key_dec),  .key_rise(dec_e));

    state_t             state_q, state_d;
    logic [W-1:0]       thresh_q, thresh_d;
    logic [W-1:0]       work_q, work_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               commit_q, commit_d;
    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    logic mode_ok, sel_ok, inc_ok, dec_ok;
    logic accepted;
    logic timeout_hit;
    bcd_t cur_digit;

    // mode+sel cancel each other; mode beats inc/dec; inc+dec cancel each other.
    assign mode_ok = mode_e & ~sel_e;
    assign sel_ok  = sel_e & ~mode_e;
    assign inc_ok  = inc_e & ~dec_e & ~mode_ok;
    assign dec_ok  = dec_e & ~inc_e & ~mode_ok;

    assign cur_digit = work_q[4*int'(sel_q) +: 4];

`ifdef THRESH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Count EDIT cycles since the last accepted edge; any other case restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != EDIT || accepted || timeout_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == EDIT) && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
    // Timeout is compiled out: EDIT lasts until the next mode edge.
    assign timeout_hit = (TIMEOUT_CYC < 0) && 1'b0;
`endif

    // Next-state, working-copy edits, commit strobe and blink generation.
    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        work_d      = work_q;
        sel_d       = sel_q;
        commit_d    = 1'b0;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        accepted    = 1'b0;

        case (state_q)
            IDLE: begin
                // Working copy shadows the committed value so edit_bcd tracks it.
                work_d      = thresh_q;
                blink_d     = 1'b1;
                blink_cnt_d = '0;
                if (mode_ok) begin
                    sel_d   = '0;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (timeout_hit) begin
                    // Abort: drop the working copy, no commit strobe.
                    work_d      = thresh_q;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    state_d     = IDLE;
                end else if (mode_ok) begin
                    thresh_d    = work_q;
                    commit_d    = 1'b1;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    // Value change lands on the current digit before sel advances.
                    if (inc_ok) begin
                        work_d[4*int'(sel_q) +: 4] = bcd_inc(cur_digit);
                        accepted = 1'b1;
                    end
                    if (dec_ok) begin
                        work_d[4*int'(sel_q) +: 4] = bcd_dec(cur_digit);
                        accepted = 1'b1;
                    end
                    if (sel_ok) begin
                        sel_d    = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + 1'b1;
                        accepted = 1'b1;
                    end
                    if (accepted) begin
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any edit in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            thresh_q    <= RESET_BCD;
            work_q      <= RESET_BCD;
            sel_q       <= '0;
            commit_q    <= 1'b0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            work_q      <= work_d;
            sel_q       <= sel_d;
            commit_q    <= commit_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign bus.thresh_bcd   = thresh_q;
    assign bus.edit_bcd     = work_q;
    assign bus.edit_active  = (state_q == EDIT);
    assign bus.digit_sel    = sel_q;
    assign bus.blink        = blink_q;
    assign bus.commit_pulse = commit_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_thresh_editor.sv
// Directed bench for thresh_editor (DIGITS=3, RESET_BCD='h200, BLINK_DIV=8,
// TIMEOUT_CYC=100). Define THRESH_TIMEOUT_EN for both bench and RTL to cover
// the timeout build.
module tb_thresh_editor;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    thresh_editor_if #(.DIGITS(3)) bus ();

    thresh_editor #(
        .DIGITS(3),
        .RESET_BCD(12'h200),
        .BLINK_DIV(8),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Clock / reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: hold a key combination 4 cycles, release, settle 4 cycles.
    task automatic press(input logic m, input logic s, input logic i, input logic d);
        bus.key_mode = m;
        bus.key_sel  = s;
        bus.key_inc  = i;
        bus.key_dec  = d;
        repeat (4) @(negedge clk);
        bus.key_mode = 1'b0;
        bus.key_sel  = 1'b0;
        bus.key_inc  = 1'b0;
        bus.key_dec  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Driver: press mode (optionally with inc), counting commit strobes.
    task automatic press_mode_count(input logic i, output int pulses, output logic [11:0] thr);
        pulses = 0;
        thr = '0;
        bus.key_mode = 1'b1;
        bus.key_inc  = i;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.key_mode = 1'b0;
                bus.key_inc  = 1'b0;
            end
            if (bus.commit_pulse === 1'b1) begin
                pulses++;
                thr = bus.thresh_bcd;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_mode = 1'b0; bus.key_sel = 1'b0; bus.key_inc = 1'b0; bus.key_dec = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.thresh_bcd !== 12'h200) begin n_fail++; $display("FAIL reset_thresh got %h want 200", bus.thresh_bcd); end
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL reset_edit got %h want 200", bus.edit_bcd); end
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", bus.edit_active); end
        n_checks++; if (bus.digit_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", bus.digit_sel); end
        n_checks++; if (bus.blink !== 1'b1) begin n_fail++; $display("FAIL reset_blink got %b want 1", bus.blink); end
        n_checks++; if (bus.commit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_commit got %b want 0", bus.commit_pulse); end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_enter_timing();
        bus.key_mode = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL enter_early got %b want 0", bus.edit_active); end
        @(negedge clk);
        n_checks++; if (bus.edit_active !== 1'b1) begin n_fail++; $display("FAIL enter_k3 got %b want 1", bus.edit_active); end
        n_checks++; if (bus.digit_sel !== 2'd0) begin n_fail++; $display("FAIL enter_sel got %0d want 0", bus.digit_sel); end
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL enter_edit got %h want 200", bus.edit_bcd); end
        n_checks++; if (bus.blink !== 1'b1) begin n_fail++; $display("FAIL enter_blink got %b want 1", bus.blink); end
        bus.key_mode = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_inc_dec();
        repeat (12) press(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.edit_bcd !== 12'h202) begin n_fail++; $display("FAIL inc12 got %h want 202", bus.edit_bcd); end
        repeat (3) press(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.edit_bcd !== 12'h209) begin n_fail++; $display("FAIL dec3 got %h want 209", bus.edit_bcd); end
        n_checks++; if (bus.thresh_bcd !== 12'h200) begin n_fail++; $display("FAIL thresh_during_edit got %h want 200", bus.thresh_bcd); end
    endtask

    task automatic test_select();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.digit_sel !== 2'd1) begin n_fail++; $display("FAIL sel_1 got %0d want 1", bus.digit_sel); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.digit_sel !== 2'd2) begin n_fail++; $display("FAIL sel_2 got %0d want 2", bus.digit_sel); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.digit_sel !== 2'd0) begin n_fail++; $display("FAIL sel_wrap got %0d want 0", bus.digit_sel); end
        press(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL sel_inc_val got %h want 200", bus.edit_bcd); end
        n_checks++; if (bus.digit_sel !== 2'd1) begin n_fail++; $display("FAIL sel_inc_sel got %0d want 1", bus.digit_sel); end
        press(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL inc_dec_val got %h want 200", bus.edit_bcd); end
        n_checks++; if (bus.digit_sel !== 2'd1) begin n_fail++; $display("FAIL inc_dec_sel got %0d want 1", bus.digit_sel); end
    endtask

    task automatic test_blink();
        bus.key_sel = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (bus.digit_sel !== 2'd2) begin n_fail++; $display("FAIL blink_sel got %0d want 2", bus.digit_sel); end
        for (int c = 0; c < 8; c++) begin
            n_checks++; if (bus.blink !== 1'b1) begin n_fail++; $display("FAIL blink_high%0d got %b want 1", c, bus.blink); end
            if (c == 3) bus.key_sel = 1'b0;
            @(negedge clk);
        end
        n_checks++; if (bus.blink !== 1'b0) begin n_fail++; $display("FAIL blink_low got %b want 0", bus.blink); end
        repeat (7) @(negedge clk);
        n_checks++; if (bus.blink !== 1'b0) begin n_fail++; $display("FAIL blink_low_end got %b want 0", bus.blink); end
        @(negedge clk);
        n_checks++; if (bus.blink !== 1'b1) begin n_fail++; $display("FAIL blink_back got %b want 1", bus.blink); end
    endtask

    task automatic test_commit();
        int pulses;
        logic [11:0] thr;
        // digit 2: 2 -> 3, digit 0: 0 -> 5, digit 1: 0 -> 4
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) press(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.edit_bcd !== 12'h345) begin n_fail++; $display("FAIL edit_345 got %h want 345", bus.edit_bcd); end
        press_mode_count(1'b0, pulses, thr);
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL commit_pulses got %0d want 1", pulses); end
        n_checks++; if (thr !== 12'h345) begin n_fail++; $display("FAIL commit_thr_at_pulse got %h want 345", thr); end
        n_checks++; if (bus.thresh_bcd !== 12'h345) begin n_fail++; $display("FAIL commit_thresh got %h want 345", bus.thresh_bcd); end
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL commit_idle got %b want 0", bus.edit_active); end
        n_checks++; if (bus.edit_bcd !== 12'h345) begin n_fail++; $display("FAIL idle_edit got %h want 345", bus.edit_bcd); end
    endtask

    task automatic test_simultaneous_mode();
        int pulses;
        logic [11:0] thr;
        press(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL mode_sel_idle got %b want 0", bus.edit_active); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.edit_active !== 1'b1) begin n_fail++; $display("FAIL reenter got %b want 1", bus.edit_active); end
        press_mode_count(1'b1, pulses, thr);
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL mode_inc_pulses got %0d want 1", pulses); end
        n_checks++; if (bus.thresh_bcd !== 12'h345) begin n_fail++; $display("FAIL mode_inc_thresh got %h want 345", bus.thresh_bcd); end
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL mode_inc_idle got %b want 0", bus.edit_active); end
    endtask

    task automatic test_timeout();
        int pulses;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) press(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.edit_bcd !== 12'h999) begin n_fail++; $display("FAIL edit_999 got %h want 999", bus.edit_bcd); end
`ifdef THRESH_TIMEOUT_EN
        repeat (86) @(negedge clk);
        n_checks++; if (bus.edit_active !== 1'b1) begin n_fail++; $display("FAIL before_timeout got %b want 1", bus.edit_active); end
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.commit_pulse === 1'b1) pulses++;
        end
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL timeout_idle got %b want 0", bus.edit_active); end
        n_checks++; if (bus.thresh_bcd !== 12'h345) begin n_fail++; $display("FAIL timeout_thresh got %h want 345", bus.thresh_bcd); end
        n_checks++; if (bus.edit_bcd !== 12'h345) begin n_fail++; $display("FAIL timeout_edit got %h want 345", bus.edit_bcd); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL timeout_pulses got %0d want 0", pulses); end
`else
        pulses = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.commit_pulse === 1'b1) pulses++;
        end
        n_checks++; if (bus.edit_active !== 1'b1) begin n_fail++; $display("FAIL no_timeout_active got %b want 1", bus.edit_active); end
        n_checks++; if (bus.edit_bcd !== 12'h999) begin n_fail++; $display("FAIL no_timeout_edit got %h want 999", bus.edit_bcd); end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL no_timeout_pulses got %0d want 0", pulses); end
`endif
    endtask

    task automatic test_reset_mid_edit();
        if (bus.edit_active !== 1'b1) press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        bus.key_inc  = 1'b1;
        bus.key_mode = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.thresh_bcd !== 12'h200) begin n_fail++; $display("FAIL mid_rst_thresh got %h want 200", bus.thresh_bcd); end
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL mid_rst_edit got %h want 200", bus.edit_bcd); end
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL mid_rst_active got %b want 0", bus.edit_active); end
        n_checks++; if (bus.digit_sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst_sel got %0d want 0", bus.digit_sel); end
        n_checks++; if (bus.blink !== 1'b1) begin n_fail++; $display("FAIL mid_rst_blink got %b want 1", bus.blink); end
        n_checks++; if (bus.commit_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_rst_commit got %b want 0", bus.commit_pulse); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (bus.edit_active !== 1'b0) begin n_fail++; $display("FAIL held_key_active got %b want 0", bus.edit_active); end
        n_checks++; if (bus.thresh_bcd !== 12'h200) begin n_fail++; $display("FAIL held_key_thresh got %h want 200", bus.thresh_bcd); end
        n_checks++; if (bus.edit_bcd !== 12'h200) begin n_fail++; $display("FAIL held_key_edit got %h want 200", bus.edit_bcd); end
        bus.key_inc  = 1'b0;
        bus.key_mode = 1'b0;
        repeat (4) @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (bus.edit_active !== 1'b1) begin n_fail++; $display("FAIL rearm_active got %b want 1", bus.edit_active); end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (bus.edit_bcd !== 12'h201) begin n_fail++; $display("FAIL rearm_inc got %h want 201", bus.edit_bcd); end
    endtask

    // Sequence and final report.
    initial begin
        rst_n = 1'b0;
        bus.key_mode = 1'b0;
        bus.key_sel  = 1'b0;
        bus.key_inc  = 1'b0;
        bus.key_dec  = 1'b0;
        @(negedge clk);
        test_reset();
        test_enter_timing();
        test_inc_dec();
        test_select();
        test_blink();
        test_commit();
        test_simultaneous_mode();
        test_timeout();
        test_reset_mid_edit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
